// File: rtl/sram_sample_sequencer_if.sv
// Request/response bundle between the sample sequencer, the SRAM controller and the NN core.
// The master side is the sequencer; the slave side is whoever answers it.
interface sram_sample_sequencer_if;
    logic        read;
    logic        write;
    logic [11:0] addr;
    logic [6:0]  TNS;
    logic [6:0]  TEW;
    logic [6:0]  PNS;
    logic [6:0]  PEW;
    logic [13:0] NSout;
    logic [13:0] EWout;
    logic        dir;
    logic [7:0]  dTime;
    logic [64:0] w_sample;
    logic [64:0] smp;
    logic        smp_valid;
    logic        smp_ready;
    logic        wb_en;
    logic [13:0] wb_NSout;
    logic [13:0] wb_EWout;
    logic        wb_dir;
    logic [7:0]  wb_dTime;

    modport master (
        output read, write, addr, w_sample, smp, smp_valid,
        input  TNS, TEW, PNS, PEW, NSout, EWout, dir, dTime,
        input  smp_ready, wb_en, wb_NSout, wb_EWout, wb_dir, wb_dTime
    );

    modport slave (
        input  read, write, addr, w_sample, smp, smp_valid,
        output TNS, TEW, PNS, PEW, NSout, EWout, dir, dTime,
        output smp_ready, wb_en, wb_NSout, wb_EWout, wb_dir, wb_dTime
    );
endinterface

// File: rtl/sram_sample_sequencer.sv
// Walks an inclusive, wrapping address range: read each sample from the SRAM controller,
// hand it to the NN core, and optionally write updated outputs back before moving on.
module sram_sample_sequencer #(
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned WR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] start_addr,
    input  logic [11:0] last_addr,
    output logic        busy,
    output logic        done,
    sram_sample_sequencer_if.master bus
);
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned SMP_W  = 65;
    localparam int unsigned KEEP_W = 28;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {IDLE, READ, PRESENT, WRITE, NEXT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]  addr_q, addr_nxt;
    logic [SMP_W-1:0]   smp_q, smp_nxt;
    logic [SMP_W-1:0]   wsmp_q, wsmp_nxt;
    logic               read_q, read_nxt;
    logic               write_q, write_nxt;
    logic               valid_q, valid_nxt;
    logic               busy_nxt, done_nxt;
    logic               rd_last, wr_last, launch;
    logic [SMP_W-1:0]   ctrl_smp;

    assign ctrl_smp = {bus.TNS, bus.TEW, bus.PNS, bus.PEW,
                       bus.NSout, bus.EWout, bus.dir, bus.dTime};
    assign rd_last  = (cnt == CNT_W'(RD_LAT - 1));
    assign wr_last  = (cnt == CNT_W'(WR_CYCLES - 1));
    assign launch   = start && !abort;

    // State and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            smp_q   <= '0;
            wsmp_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            addr_q  <= addr_nxt;
            smp_q   <= smp_nxt;
            wsmp_q  <= wsmp_nxt;
            read_q  <= read_nxt;
            write_q <= write_nxt;
            valid_q <= valid_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state decode; abort overrides everything, including a start in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = READ;
            READ:    if (rd_last) state_nxt = PRESENT;
            PRESENT: if (bus.smp_ready) state_nxt = bus.wb_en ? WRITE : NEXT;
            WRITE:   if (wr_last) state_nxt = NEXT;
            NEXT:    state_nxt = (addr_q == last_addr) ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Datapath and next values of the registered outputs
    always_comb begin
        cnt_nxt  = '0;
        addr_nxt = addr_q;
        smp_nxt  = smp_q;
        wsmp_nxt = wsmp_q;
        case (state)
            IDLE: if (launch) addr_nxt = start_addr;
            READ: begin
                if (rd_last) begin
                    if (!abort) smp_nxt = ctrl_smp;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESENT: begin
                if (bus.smp_ready && bus.wb_en && !abort)
                    wsmp_nxt = {smp_q[SMP_W-1 -: KEEP_W], bus.wb_NSout, bus.wb_EWout,
                                bus.wb_dir, bus.wb_dTime};
            end
            WRITE: if (!wr_last) cnt_nxt = cnt + CNT_W'(1);
            NEXT: begin
                if (addr_q != last_addr && !abort) addr_nxt = addr_q + ADDR_W'(1);
            end
            default: ;
        endcase
        if (abort) cnt_nxt = '0;

        read_nxt  = (state_nxt == READ);
        write_nxt = (state_nxt == WRITE);
        valid_nxt = (state_nxt == PRESENT);
        busy_nxt  = (state_nxt != IDLE);
        // addr does not move between PRESENT/WRITE and NEXT, so the end test can be made early
        done_nxt  = (state_nxt == NEXT) && (addr_q == last_addr);
    end

    assign bus.read      = read_q;
    assign bus.write     = write_q;
    assign bus.addr      = addr_q;
    assign bus.smp       = smp_q;
    assign bus.smp_valid = valid_q;
    assign bus.w_sample  = wsmp_q;
endmodule

// File: tb/tb_sram_sample_sequencer.sv
// Directed bench for sram_sample_sequencer: controller model with fixed read latency,
// scoreboards for visited addresses, presented samples and write-backs.
module tb_sram_sample_sequencer;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned WR_CYCLES = 2;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] start_addr = '0;
    logic [11:0] last_addr = '0;
    logic        busy, done;

    sram_sample_sequencer_if bus();

    sram_sample_sequencer #(.RD_LAT(RD_LAT), .WR_CYCLES(WR_CYCLES)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .start_addr(start_addr), .last_addr(last_addr),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    logic [11:0] exp_addr_q[$];
    logic [64:0] exp_smp_q[$];
    logic [76:0] exp_wr_q[$];
    int          rd_len = 0;
    int          wr_len = 0;
    int          done_cnt = 0;
    logic [11:0] rd_addr = '0;
    logic [76:0] wr_ref = '0;
    bit          mon_en = 1'b1;

    // Controller model: data is only meaningful in the last cycle of a read burst
    int          rd_run = 0;
    bit          ovr_en = 1'b0;
    logic [64:0] ovr_val = '0;
    logic        rd_ok;
    logic [64:0] ctrl;

    function automatic logic [64:0] gen(input logic [11:0] a);
        return {7'(a * 12'd3 + 12'd1), 7'(a ^ 12'h02A), 7'(a + 12'd5), 7'(a >> 1),
                14'({2'b00, a} * 14'd7), 14'({2'b00, ~a}), a[0], 8'(a + 12'h011)};
    endfunction

    always @(posedge clk) rd_run <= bus.read ? rd_run + 1 : 0;
    assign rd_ok = bus.read && (rd_run == int'(RD_LAT - 1));
    assign ctrl  = !rd_ok ? {65{1'b1}} : (ovr_en ? ovr_val : gen(bus.addr));
    assign {bus.TNS, bus.TEW, bus.PNS, bus.PEW, bus.NSout, bus.EWout, bus.dir, bus.dTime} = ctrl;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Per-cycle protocol observation; inputs are final for the coming edge when this runs
    task automatic monitor();
        if (done === 1'b1) done_cnt++;
        if (!mon_en) begin
            rd_len = 0;
            wr_len = 0;
            return;
        end
        if (bus.read || bus.write)
            check("rd_wr_exclusive", 128'(bus.read && bus.write), 128'(0));
        if (bus.read) begin
            if (rd_len == 0) begin
                check("read_expected", 128'(exp_addr_q.size() != 0), 128'(1));
                if (exp_addr_q.size() != 0) check("read_addr", 128'(bus.addr), 128'(exp_addr_q.pop_front()));
                rd_addr = bus.addr;
            end else begin
                check("read_addr_stable", 128'(bus.addr), 128'(rd_addr));
            end
            rd_len++;
        end else if (rd_len != 0) begin
            check("read_len", 128'(rd_len), 128'(RD_LAT));
            rd_len = 0;
        end
        if (bus.write) begin
            if (wr_len == 0) begin
                check("write_expected", 128'(exp_wr_q.size() != 0), 128'(1));
                wr_ref = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 77'('1);
            end
            check("write_addr_data", 128'({bus.addr, bus.w_sample}), 128'(wr_ref));
            wr_len++;
        end else if (wr_len != 0) begin
            check("write_len", 128'(wr_len), 128'(WR_CYCLES));
            wr_len = 0;
        end
        if (bus.smp_valid && bus.smp_ready) begin
            check("smp_expected", 128'(exp_smp_q.size() != 0), 128'(1));
            if (exp_smp_q.size() != 0) check("smp_data", 128'(bus.smp), 128'(exp_smp_q.pop_front()));
        end
        if (done === 1'b1) check("done_while_busy", 128'(busy), 128'(1));
    endtask

    task automatic step();
        monitor();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_pass(input logic [11:0] sa, input logic [11:0] la);
        logic [11:0] a;
        a = sa;
        forever begin
            exp_addr_q.push_back(a);
            exp_smp_q.push_back(ovr_en ? ovr_val : gen(a));
            if (a == la) break;
            a = a + 12'd1;
        end
    endtask

    task automatic kick(input logic [11:0] sa, input logic [11:0] la);
        start_addr = sa;
        last_addr  = la;
        start      = 1'b1;
        step();
        start      = 1'b0;
        check("busy_after_start", 128'(busy), 128'(1));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 128'(busy), 128'(0));
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_addr_q"}, 128'(exp_addr_q.size()), 128'(0));
        check({tag, "_smp_q"}, 128'(exp_smp_q.size()), 128'(0));
        check({tag, "_wr_q"}, 128'(exp_wr_q.size()), 128'(0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_read"}, 128'(bus.read), 128'(0));
        check({tag, "_write"}, 128'(bus.write), 128'(0));
        check({tag, "_valid"}, 128'(bus.smp_valid), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_addr"}, 128'(bus.addr), 128'(0));
        check({tag, "_smp"}, 128'(bus.smp), 128'(0));
        check({tag, "_wsample"}, 128'(bus.w_sample), 128'(0));
    endtask

    initial begin
        int          d0;
        int          n;
        logic [64:0] w_exp;
        logic [64:0] g;

        bus.smp_ready = 1'b1;
        bus.wb_en     = 1'b0;
        bus.wb_NSout  = '0;
        bus.wb_EWout  = '0;
        bus.wb_dir    = 1'b0;
        bus.wb_dTime  = '0;

        @(negedge clk);
        check_zero("reset");
        n_rst = 1'b1;
        step();

        // Three-address pass, always ready, no write-back
        push_pass(12'd0, 12'd2);
        d0 = done_cnt;
        kick(12'd0, 12'd2);
        wait_idle("t1_finish", 100);
        check("t1_done_once", 128'(done_cnt), 128'(d0 + 1));
        check_drained("t1");

        // Single address with write-back of replacement outputs
        ovr_en  = 1'b1;
        ovr_val = {7'hA, 7'hB, 7'hC, 7'hD, 14'h1234, 14'h0567, 1'b0, 8'h3C};
        bus.wb_en = 1'b1; bus.wb_NSout = 14'h9A; bus.wb_EWout = 14'h9B;
        bus.wb_dir = 1'b1; bus.wb_dTime = 8'h12;
        w_exp = {7'hA, 7'hB, 7'hC, 7'hD, 14'h9A, 14'h9B, 1'b1, 8'h12};
        exp_wr_q.push_back({12'd30, w_exp});
        push_pass(12'd30, 12'd30);
        d0 = done_cnt;
        kick(12'd30, 12'd30);
        wait_idle("t2_finish", 100);
        check("t2_done_once", 128'(done_cnt), 128'(d0 + 1));
        check("t2_wsample_hold", 128'(bus.w_sample), 128'(w_exp));
        check_drained("t2");
        ovr_en = 1'b0;
        bus.wb_en = 1'b0;

        // Consumer stalls for ten cycles
        bus.smp_ready = 1'b0;
        push_pass(12'd5, 12'd5);
        d0 = done_cnt;
        kick(12'd5, 12'd5);
        n = 0;
        while (bus.smp_valid !== 1'b1 && n < 20) begin step(); n++; end
        check("t3_valid_seen", 128'(bus.smp_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", 128'(bus.smp_valid), 128'(1));
            check("t3_hold_smp", 128'(bus.smp), 128'(gen(12'd5)));
            check("t3_hold_idle_bus", 128'({bus.read, bus.write}), 128'(0));
            step();
        end
        bus.smp_ready = 1'b1;
        step();
        check("t3_valid_drop", 128'(bus.smp_valid), 128'(0));
        wait_idle("t3_finish", 100);
        check("t3_done_once", 128'(done_cnt), 128'(d0 + 1));
        check_drained("t3");

        // Range wrapping through address 0
        push_pass(12'd4094, 12'd1);
        d0 = done_cnt;
        kick(12'd4094, 12'd1);
        wait_idle("t4_finish", 200);
        check("t4_done_once", 128'(done_cnt), 128'(d0 + 1));
        check("t4_last_addr", 128'(bus.addr), 128'(1));
        check_drained("t4");

        // Abort in the second write cycle
        g = gen(12'd7);
        bus.wb_en = 1'b1; bus.wb_NSout = 14'h3A5; bus.wb_EWout = 14'h15C;
        bus.wb_dir = 1'b0; bus.wb_dTime = 8'hE7;
        exp_wr_q.push_back({12'd7, g[64:37], 14'h3A5, 14'h15C, 1'b0, 8'hE7});
        push_pass(12'd7, 12'd7);
        d0 = done_cnt;
        kick(12'd7, 12'd7);
        n = 0;
        while (bus.write !== 1'b1 && n < 20) begin step(); n++; end
        check("t5_write_seen", 128'(bus.write), 128'(1));
        step();
        check("t5_write_cycle2", 128'(bus.write), 128'(1));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_write_cut", 128'(bus.write), 128'(0));
        check("t5_idle", 128'(busy), 128'(0));
        check("t5_no_valid", 128'(bus.smp_valid), 128'(0));
        check("t5_addr_kept", 128'(bus.addr), 128'(7));
        check("t5_smp_kept", 128'(bus.smp), 128'(g));
        step();
        check("t5_no_done", 128'(done_cnt), 128'(d0));
        check_drained("t5");
        bus.wb_en = 1'b0;

        // Abort beats start in IDLE
        start_addr = 12'd9; abort = 1'b1; start = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("t5_abort_start_busy", 128'(busy), 128'(0));
        check("t5_abort_start_read", 128'(bus.read), 128'(0));
        step();
        check("t5_abort_start_stay", 128'(busy), 128'(0));

        // Clean restart after abort
        push_pass(12'd8, 12'd9);
        d0 = done_cnt;
        kick(12'd8, 12'd9);
        wait_idle("t5_restart_finish", 100);
        check("t5_restart_done", 128'(done_cnt), 128'(d0 + 1));
        check_drained("t5r");

        // Asynchronous reset in the middle of a read
        mon_en = 1'b0;
        kick(12'd12, 12'd14);
        check("t6_in_read", 128'(bus.read), 128'(1));
        n_rst = 1'b0;
        #1;
        check_zero("t6_reset");
        step();
        n_rst = 1'b1;
        mon_en = 1'b1;
        step();
        check("t6_idle_after", 128'(busy), 128'(0));
        push_pass(12'd20, 12'd20);
        d0 = done_cnt;
        kick(12'd20, 12'd20);
        wait_idle("t6_finish", 100);
        check("t6_done", 128'(done_cnt), 128'(d0 + 1));
        check_drained("t6");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/sram_sample_sequencer.md
Name: sram_sample_sequencer

Overview:
- NN-side initiator that walks a range of training-sample addresses through the SRAM controller's read/write/addr request interface.
- Per address: issues a read, waits the fixed controller latency, and latches the returned sample fields.
- Offers the latched sample to the neural-net core over a valid/ready handshake.
- Optionally writes updated outputs and direction/time back to the same address before moving on.

Parameters:
- RD_LAT, 2: cycles read is held high before the controller outputs are valid and latched (legal 1..15).
- WR_CYCLES, 2: cycles write is held high with address and data stable (legal 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- abort  in  1  terminate the pass; highest priority after reset.
- start_addr  in  12  first sample address.
- last_addr  in  12  final sample address, inclusive.
- read  out  1  read request to the controller.
- write  out  1  write request to the controller.
- addr  out  12  request address to the controller.
- TNS, TEW, PNS, PEW  in  7 each  sample inputs returned by the controller.
- NSout, EWout  in  14 each  stored outputs returned by the controller.
- dir  in  1  stored direction returned by the controller.
- dTime  in  8  stored time returned by the controller.
- w_sample  out  65  write fields to the controller, packed {TNS,TEW,PNS,PEW,NSout,EWout,dir,dTime}, MSB first.
- smp  out  65  latched sample to the NN, same packing.
- smp_valid  out  1  smp is valid.
- smp_ready  in  1  NN accepts smp.
- wb_en  in  1  with the accepting smp_ready: write back this sample.
- wb_NSout, wb_EWout  in  14 each  replacement NSout/EWout for write-back.
- wb_dir  in  1  replacement dir for write-back.
- wb_dTime  in  8  replacement dTime for write-back.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a pass completes normally.

Behaviour:
- Reset (async, n_rst=0):
  - State IDLE.
  - read, write, smp_valid, busy, done = 0.
  - addr, smp, w_sample = 0.
  - Both latency counters = 0.
- States: IDLE, READ, PRESENT, WRITE, NEXT.
- IDLE:
  - start=1 loads addr<=start_addr, next state READ.
  - start is ignored in every other state.
- READ:
  - read=1 for exactly RD_LAT consecutive cycles, addr stable.
  - On the last cycle, all eight controller fields latch into smp.
  - Next state PRESENT: read=0, smp_valid=1.
- PRESENT:
  - smp and smp_valid hold until smp_ready=1.
  - On acceptance, smp_valid drops next cycle.
  - wb_en=1: w_sample <= {smp[64:37], wb_NSout, wb_EWout, wb_dir, wb_dTime}, next state WRITE.
  - wb_en=0: next state NEXT.
  - wb_en is ignored when smp_ready=0.
- WRITE:
  - write=1 for exactly WR_CYCLES cycles, addr and w_sample stable, read=0.
  - Then next state NEXT.
- NEXT (one cycle, read=write=0):
  - addr==last_addr: done=1 this cycle, next state IDLE.
  - Otherwise addr <= addr+1 (12-bit, 4095 wraps to 0), next state READ.
  - start_addr > last_addr therefore wraps through 0.
  - start_addr==last_addr processes exactly one sample.
- read and write are never high in the same cycle.
- Back-to-back read requests are separated by at least one NEXT cycle.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, read=write=smp_valid=0, done=0, counters cleared.
  - addr and smp retain their last values.
  - A write in progress is truncated.
- abort and start together in IDLE: abort wins, stay IDLE.
- Async reset mid-pass: immediate return to reset values. No completion of a pending write.
- w_sample holds its last value outside WRITE.

Test Plan:
- RD_LAT=2, WR_CYCLES=2, start_addr=0, last_addr=2, smp_ready tied 1, wb_en=0 -> read high 2 cycles at each addr 0,1,2; smp equals controller data; done pulses once; busy is high from the cycle after start through the done cycle.
- Single address 30, controller returns TNS=0xA, TEW=0xB, PNS=0xC, PEW=0xD; accept with wb_en=1, wb_NSout=0x9A, wb_EWout=0x9B, wb_dir=1, wb_dTime=0x12 -> write=1 for 2 cycles at addr 30; w_sample = {A,B,C,D,0x9A,0x9B,1,0x12}.
- Hold smp_ready=0 for 10 cycles in PRESENT -> smp_valid and smp stable; no read/write activity; pass resumes on the first smp_ready=1.
- start_addr=4094, last_addr=1 -> addresses visited 4094, 4095, 0, 1; done after 1.
- Assert abort during the second WRITE cycle -> write=0 next cycle, state IDLE, no done; a later start restarts cleanly.
- Pull n_rst low mid-READ -> all outputs 0 immediately; start after release begins a new pass at start_addr.
